// File: rtl/qracc_sram_arbiter_if.sv
// Request/response bundle shared by the requesters, qracc_sram_arbiter and the SRAM controller.
// slave is the arbiter's view; master is the view of the surrounding requesters and SRAM.
interface qracc_sram_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned numRows = 128,
    parameter int unsigned numCols = 32
);
    logic [NUM_REQ-1:0]                  req_wr_i;
    logic [NUM_REQ-1:0]                  req_valid_i;
    logic [NUM_REQ*$clog2(numRows)-1:0]  req_addr_i;
    logic [NUM_REQ*numCols-1:0]          req_wr_data_i;
    logic [NUM_REQ-1:0]                  req_ready_o;
    logic [NUM_REQ-1:0]                  req_rd_valid_o;
    logic [numCols-1:0]                  req_rd_data_o;

    logic                                sram_rq_wr_o;
    logic                                sram_rq_valid_o;
    logic [$clog2(numRows)-1:0]          sram_addr_o;
    logic [numCols-1:0]                  sram_wr_data_o;
    logic                                sram_rq_ready_i;
    logic                                sram_rd_valid_i;
    logic [numCols-1:0]                  sram_rd_data_i;

    logic                                err_orphan_rd_o;

    modport slave (
        input  req_wr_i, req_valid_i, req_addr_i, req_wr_data_i,
        input  sram_rq_ready_i, sram_rd_valid_i, sram_rd_data_i,
        output req_ready_o, req_rd_valid_o, req_rd_data_o,
        output sram_rq_wr_o, sram_rq_valid_o, sram_addr_o, sram_wr_data_o,
        output err_orphan_rd_o
    );

    modport master (
        output req_wr_i, req_valid_i, req_addr_i, req_wr_data_i,
        output sram_rq_ready_i, sram_rd_valid_i, sram_rd_data_i,
        input  req_ready_o, req_rd_valid_o, req_rd_data_o,
        input  sram_rq_wr_o, sram_rq_valid_o, sram_addr_o, sram_wr_data_o,
        input  err_orphan_rd_o
    );
endinterface

// File: rtl/qracc_sram_arbiter.sv
// Round-robin arbiter sharing one SRAM port between NUM_REQ requesters, with an ID FIFO
// steering read responses back in order. Define QRACC_ARB_FIXED_PRIO_EN for fixed priority.
module qracc_sram_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned numRows         = 128,
    parameter int unsigned numCols         = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input logic                clk,
    input logic                rst,
    qracc_sram_arbiter_if.slave bus
);
    localparam int unsigned AW = $clog2(numRows);
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [IW-1:0] rr_ptr_q;
    logic          lock_q;
    logic [IW-1:0] lock_idx_q;
    logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          err_q;

    logic [IW-1:0] grant;
    logic [IW-1:0] scan_cand;
    logic          scan_found;
    logic          g_valid;
    logic          g_wr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          stall;
    logic          accept;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // A held grant wins; otherwise scan upward from rr_ptr_q with wrap.
    always_comb begin
        grant      = lock_q ? lock_idx_q : rr_ptr_q;
        scan_found = lock_q;
        scan_cand  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            scan_cand = IW'((int'(rr_ptr_q) + i) % int'(NUM_REQ));
            if (!scan_found && bus.req_valid_i[scan_cand]) begin
                grant      = scan_cand;
                scan_found = 1'b1;
            end
        end
    end

    assign g_valid    = bus.req_valid_i[grant];
    assign g_wr       = bus.req_wr_i[grant];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
    assign pop        = bus.sram_rd_valid_i && !fifo_empty && !rst;
    // A pop in the same cycle frees the slot the new read needs.
    assign stall      = fifo_full && !g_wr && !pop;

    assign bus.sram_rq_valid_o = g_valid && !stall && !rst;
    assign bus.sram_rq_wr_o    = g_wr;
    assign bus.sram_addr_o     = bus.req_addr_i[grant*AW +: AW];
    assign bus.sram_wr_data_o  = bus.req_wr_data_i[grant*numCols +: numCols];
    assign bus.req_rd_data_o   = bus.sram_rd_data_i;
    assign bus.err_orphan_rd_o = err_q;

    assign accept = bus.sram_rq_valid_o && bus.sram_rq_ready_i;
    assign push   = accept && !g_wr;

    always_comb begin
        bus.req_ready_o = '0;
        if (!rst && bus.sram_rq_ready_i && !stall) begin
            bus.req_ready_o[grant] = 1'b1;
        end
        bus.req_rd_valid_o = '0;
        if (pop) begin
            bus.req_rd_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
        end
    end

`ifdef QRACC_ARB_FIXED_PRIO_EN
    assign rr_ptr_q = '0;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (accept) begin
            rr_ptr_q <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                lock_q <= 1'b0;
            end else if (g_valid) begin
                lock_q     <= 1'b1;
                lock_idx_q <= grant;
            end else begin
                lock_q <= 1'b0;
            end
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (bus.sram_rd_valid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_q[wr_ptr_q] <= grant;
        end
    end
endmodule

// File: tb/tb_qracc_sram_arbiter.sv
// Bench for qracc_sram_arbiter: directed scenarios plus random traffic, all compared against a
// transaction-level model (queue of outstanding reads, memory array, round-robin pointer).
module tb_qracc_sram_arbiter;
    localparam int NREQ = 2;
    localparam int ROWS = 128;
    localparam int COLS = 32;
    localparam int MAXO = 2;
    localparam int AW   = $clog2(ROWS);

    typedef struct {
        int              id;
        logic [COLS-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qracc_sram_arbiter_if #(.NUM_REQ(NREQ), .numRows(ROWS), .numCols(COLS)) bus ();

    qracc_sram_arbiter #(
        .NUM_REQ(NREQ), .numRows(ROWS), .numCols(COLS), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [NREQ-1:0] vld = '0;
    logic [NREQ-1:0] wr = '0;
    logic [AW-1:0]   addr [NREQ];
    logic [COLS-1:0] wdata [NREQ];
    logic            sram_rdy = 1'b0;
    logic            rdv = 1'b0;
    logic [COLS-1:0] rdd = '0;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            bus.req_addr_i[k*AW +: AW]         = addr[k];
            bus.req_wr_data_i[k*COLS +: COLS]  = wdata[k];
        end
    end
    assign bus.req_valid_i     = vld;
    assign bus.req_wr_i        = wr;
    assign bus.sram_rq_ready_i = sram_rdy;
    assign bus.sram_rd_valid_i = rdv;
    assign bus.sram_rd_data_i  = rdd;

    // Reference model state
    int              exp_rr;
    bit              exp_lock;
    int              exp_lidx;
    bit              exp_err;
    rsp_t            idq [$];
    logic [COLS-1:0] mem [ROWS];
    logic [COLS-1:0] sram_q [$];
    int              wait_cnt [NREQ];

    int c_g;
    bit c_gv, c_gw, c_pop, c_acc, c_rst;
    bit auto_req, auto_resp;
    int resp_pct;

    logic [NREQ-1:0] s_ready, s_rdv;
    logic            s_val, s_err;
    logic [AW-1:0]   s_addr;
    logic [COLS-1:0] s_rdd;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, want, $time);
        end
    endtask

    function automatic int model_grant();
        if (exp_lock) return exp_lidx;
        for (int i = 0; i < NREQ; i++) begin
            if (vld[(exp_rr + i) % NREQ]) return (exp_rr + i) % NREQ;
        end
        return exp_rr;
    endfunction

    task automatic check_outputs();
        bit          stall, e_val;
        logic [31:0] e_rdv;
        c_rst = rst;
        c_g   = model_grant();
        c_gv  = vld[c_g];
        c_gw  = wr[c_g];
        c_pop = rdv && (idq.size() > 0);
        stall = (idq.size() == MAXO) && !c_gw && !c_pop;
        e_val = !rst && c_gv && !stall;
        c_acc = e_val && sram_rdy;
        s_ready = bus.req_ready_o;
        s_rdv   = bus.req_rd_valid_o;
        s_val   = bus.sram_rq_valid_o;
        s_err   = bus.err_orphan_rd_o;
        s_addr  = bus.sram_addr_o;
        s_rdd   = bus.req_rd_data_o;
        check_eq("sram_rq_valid", bus.sram_rq_valid_o, e_val);
        if (e_val) begin
            check_eq("sram_addr", bus.sram_addr_o, addr[c_g]);
            check_eq("sram_wr", bus.sram_rq_wr_o, c_gw);
            if (c_gw) check_eq("sram_wr_data", bus.sram_wr_data_o, wdata[c_g]);
        end
        if (rst) check_eq("req_ready_rst", bus.req_ready_o, 0);
        else if (exp_lock || vld != '0)
            check_eq("req_ready", bus.req_ready_o, (sram_rdy && !stall) ? (32'd1 << c_g) : 0);
        e_rdv = (!rst && c_pop) ? (32'd1 << idq[0].id) : 0;
        check_eq("req_rd_valid", bus.req_rd_valid_o, e_rdv);
        if (e_rdv != 0) check_eq("req_rd_data", bus.req_rd_data_o, idq[0].data);
        check_eq("err_orphan", bus.err_orphan_rd_o, exp_err);
    endtask

    task automatic update_model();
        if (c_rst) begin
            exp_rr = 0;
            exp_lock = 0;
            exp_err = 0;
            idq.delete();
            sram_q.delete();
            for (int k = 0; k < NREQ; k++) wait_cnt[k] = 0;
            return;
        end
        if (rdv && idq.size() == 0) exp_err = 1;
        if (c_pop) void'(idq.pop_front());
        if (rdv && sram_q.size() > 0) void'(sram_q.pop_front());
        if (c_acc) begin
`ifndef QRACC_ARB_FIXED_PRIO_EN
            check_eq("fairness", wait_cnt[c_g] <= NREQ - 1, 1);
            exp_rr = (c_g + 1) % NREQ;
`endif
            for (int k = 0; k < NREQ; k++) if (k != c_g && vld[k]) wait_cnt[k]++;
            wait_cnt[c_g] = 0;
            exp_lock = 0;
            if (c_gw) mem[addr[c_g]] = wdata[c_g];
            else begin
                idq.push_back('{c_g, mem[addr[c_g]]});
                sram_q.push_back(mem[addr[c_g]]);
            end
            if (auto_req) vld[c_g] = 1'b0;
        end else if (c_gv) begin
            exp_lock = 1;
            exp_lidx = c_g;
        end else begin
            exp_lock = 0;
        end
        for (int k = 0; k < NREQ; k++) if (!vld[k]) wait_cnt[k] = 0;
    endtask

    // One clock: optional random drive, check at negedge, advance model after posedge.
    task automatic cycle();
        if (auto_resp) begin
            rdv = (sram_q.size() > 0) && ($urandom_range(99, 0) < resp_pct);
            rdd = rdv ? sram_q[0] : $urandom;
        end
        if (auto_req) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!vld[k] && $urandom_range(1, 0) == 1) begin
                    vld[k]   = 1'b1;
                    wr[k]    = 1'($urandom_range(1, 0));
                    addr[k]  = AW'($urandom_range(15, 0));
                    wdata[k] = $urandom;
                end
            end
            sram_rdy = ($urandom_range(3, 0) != 0);
        end
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        update_model();
    endtask

    initial begin
        for (int i = 0; i < ROWS; i++) mem[i] = $urandom;
        mem[5] = 32'h0505_A5A5;
        mem[9] = 32'h0909_C3C3;
        for (int k = 0; k < NREQ; k++) begin
            addr[k] = '0;
            wdata[k] = '0;
            wait_cnt[k] = 0;
        end
        exp_rr = 0; exp_lock = 0; exp_lidx = 0; exp_err = 0;
        auto_req = 0; auto_resp = 0; resp_pct = 100;

        // Reset: outputs forced low while rst is high, then idle state
        rst = 1'b1;
        vld = 2'b11;
        sram_rdy = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        check_eq("rst_ready", s_ready, 0);
        check_eq("rst_valid", s_val, 0);
        rst = 1'b0;
        vld = '0;
        cycle();
        check_eq("rst_err", s_err, 0);

        // Round-robin reads with 1-cycle responses
        auto_resp = 1;
        wr = '0;
        addr[0] = 5;
        addr[1] = 9;
        vld = 2'b11;
        for (int i = 0; i < 4; i++) begin
            cycle();
`ifndef QRACC_ARB_FIXED_PRIO_EN
            check_eq("rr_ready", s_ready, (i % 2 == 0) ? 1 : 2);
            if (i > 0) check_eq("rr_rd_valid", s_rdv, (i % 2 == 1) ? 1 : 2);
`endif
        end
        vld = '0;
        cycle();
        cycle();

        // Lock: R1 write held through 4 not-ready cycles, R0 joins in cycle 2
        sram_rdy = 1'b0;
        vld = 2'b10;
        wr = 2'b10;
        addr[1] = 3;
        wdata[1] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                vld[0] = 1'b1;
                addr[0] = 3;
            end
            cycle();
            check_eq("lock_addr", s_addr, 3);
            check_eq("lock_ready", s_ready, 0);
        end
        sram_rdy = 1'b1;
        cycle();
        check_eq("lock_r1_first", s_ready, 2);
        vld[1] = 1'b0;
        cycle();
        check_eq("lock_r0_next", s_ready, 1);
        vld = '0;
        cycle();
        check_eq("lock_rd_valid", s_rdv, 1);
        check_eq("lock_rd_data", s_rdd, 32'hDEAD_BEEF);

        // FIFO full: third read stalls until a pop arrives in the same cycle
        auto_resp = 0;
        rdv = 1'b0;
        vld = 2'b01;
        wr = '0;
        addr[0] = 10;
        cycle();
        cycle();
        cycle();
        check_eq("full_ready", s_ready, 0);
        check_eq("full_valid", s_val, 0);
        rdv = 1'b1;
        rdd = sram_q[0];
        cycle();
        check_eq("full_pop_ready", s_ready, 1);
        check_eq("full_pop_rdv", s_rdv, 1);
        rdv = 1'b0;
        cycle();
        check_eq("full_still", s_ready, 0);

        // Write bypasses the full FIFO
        vld = '0;
        cycle();
        vld = 2'b10;
        wr = 2'b10;
        addr[1] = 7;
        wdata[1] = 32'h1234_5678;
        cycle();
        check_eq("wr_ready", s_ready, 2);
        check_eq("wr_addr", s_addr, 7);
        vld = '0;
        auto_resp = 1;
        for (int i = 0; i < 3; i++) cycle();

        // Orphan response
        auto_resp = 0;
        rdv = 1'b1;
        rdd = 32'hBAD0_BAD0;
        cycle();
        check_eq("orphan_rdv", s_rdv, 0);
        check_eq("orphan_err_same", s_err, 0);
        rdv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("orphan_err_sticky", s_err, 1);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check_eq("orphan_err_cleared", s_err, 0);

        // Reset with two reads outstanding discards their IDs
        vld = 2'b01;
        wr = '0;
        addr[0] = 20;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check_eq("mid_rst_ready", s_ready, 0);
        check_eq("mid_rst_valid", s_val, 0);
        check_eq("mid_rst_rdv", s_rdv, 0);
        rst = 1'b0;
        vld = '0;
        cycle();
        check_eq("mid_rst_err", s_err, 0);
        rdv = 1'b1;
        rdd = '0;
        cycle();
        check_eq("post_rst_rdv", s_rdv, 0);
        rdv = 1'b0;
        cycle();
        check_eq("post_rst_orphan", s_err, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;

`ifdef QRACC_ARB_FIXED_PRIO_EN
        vld = 2'b11;
        wr = 2'b11;
        sram_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check_eq("fixed_r0_wins", s_ready, 1);
        end
        vld = '0;
        cycle();
`endif

        // Random traffic against the model
        auto_req = 1;
        auto_resp = 1;
        resp_pct = 50;
        for (int i = 0; i < 3000; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
